ks_multiword_adder: RTL and testbench



---
 rtl/ks_multiword_adder.sv | 123 ++++++++++++
 tb/tb_ks_multiword_adder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ks_multiword_adder.sv
// Multi-cycle wide adder. One 16-bit Kogge-Stone slice is reused for every
// word, least-significant word first, with the carry held in a register between words.

module kogge_stone #(
    parameter int NBITS = 16
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             carry_in,
    output logic [NBITS-1:0] sum_out,
    output logic             carry_out
);
    localparam int LV = $clog2(NBITS);

    logic [NBITS-1:0]        p0;
    logic [LV:0][NBITS-1:0]  g;
    logic [LV:0][NBITS-1:0]  p;

    assign p0   = a ^ b;
    // The carry-in is folded into bit 0's generate, so the prefix tree needs no extra column
    assign g[0] = (a & b) | {{(NBITS-1){1'b0}}, p0[0] & carry_in};
    assign p[0] = p0;

    for (genvar lv = 0; lv < LV; lv++) begin : g_lvl
        localparam int D = 1 << lv;
        for (genvar i = 0; i < NBITS; i++) begin : g_bit
            if (i >= D) begin : g_cmb
                assign g[lv+1][i] = g[lv][i] | (p[lv][i] & g[lv][i-D]);
                assign p[lv+1][i] = p[lv][i] & p[lv][i-D];
            end else begin : g_pass
                assign g[lv+1][i] = g[lv][i];
                assign p[lv+1][i] = p[lv][i];
            end
        end
    end

    assign sum_out   = p0 ^ {g[LV][NBITS-2:0], carry_in};
    assign carry_out = g[LV][NBITS-1];
endmodule

module ks_multiword_adder #(
    parameter int NBITS = 16,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBITS*WORDS-1:0] a,
    input  logic [NBITS*WORDS-1:0] b,
    input  logic                   carry_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBITS*WORDS-1:0] sum,
    output logic                   carry_out,
    output logic                   ovf
);
    localparam int W  = NBITS * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [W-1:0]     a_sh, b_sh, sum_sh;
    logic             carry_r;
    logic [IW-1:0]    idx;
    logic             msb_a, msb_b;
    logic [NBITS-1:0] ks_sum;
    logic             ks_cout;

    kogge_stone #(.NBITS(NBITS)) u_ks (
        .a         (a_sh[NBITS-1:0]),
        .b         (b_sh[NBITS-1:0]),
        .carry_in  (carry_r),
        .sum_out   (ks_sum),
        .carry_out (ks_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            msb_a   <= 1'b0;
            msb_b   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh    <= a;
                    b_sh    <= b;
                    carry_r <= carry_in;
                    msb_a   <= a[W-1];
                    msb_b   <= b[W-1];
                    idx     <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    // Each slice result enters at the top; after WORDS shifts slice 0 sits at the bottom
                    sum_sh  <= {ks_sum, sum_sh[W-1:NBITS]};
                    a_sh    <= a_sh >> NBITS;
                    b_sh    <= b_sh >> NBITS;
                    carry_r <= ks_cout;
                    idx     <= idx + 1'b1;
                    if (idx == LAST) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_sh;
    assign carry_out = carry_r;
    assign ovf       = out_valid && (msb_a == msb_b) && (sum_sh[W-1] != msb_a);
endmodule

// File: tb/tb_ks_multiword_adder.sv
// Directed bench for ks_multiword_adder: a table of hand-computed adds plus
// hand-written backpressure and mid-operation reset sequences.

module tb_ks_multiword_adder;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    ks_multiword_adder #(.NBITS(16), .WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents operands at a falling edge, accepts them on the next rising
    // edge and returns the number of rising edges until out_valid is seen.
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                          input bit scramble, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", W'(in_ready), W'(1));
        a = va; b = vb; carry_in = vc; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                carry_in = 1'($urandom);
                chk("in_ready_run", W'(in_ready), W'(0));
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_take", W'(out_valid), W'(0));
        chk("in_ready_after_take", W'(in_ready), W'(1));
    endtask

    vec_t vecs[7];

    initial begin
        int lat;
        logic [W-1:0] hold_sum;
        logic         hold_cout;
        bit           seen;

        vecs[0] = '{"slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{"full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{"signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{"neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[4] = '{"minus_two", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
        vecs[5] = '{"mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 64'h2222_2222_2222_2212, 1'b0, 1'b0};
        vecs[6] = '{"small", 64'd3, 64'd5, 1'b0, 64'd8, 1'b0, 1'b0};

        // Reset held three cycles
        repeat (3) @(negedge clk);
        chk("rst_in_ready_during", W'(in_ready), W'(1));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_sum", sum, 64'h0);
        chk("rst_carry_out", W'(carry_out), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, lat);
            chk({vecs[i].name, "_latency"}, W'(lat), W'(4));
            chk({vecs[i].name, "_sum"}, sum, vecs[i].sum);
            chk({vecs[i].name, "_cout"}, W'(carry_out), W'(vecs[i].cout));
            chk({vecs[i].name, "_ovf"}, W'(ovf), W'(vecs[i].ovf));
            take();
        end

        // Backpressure with operand inputs scrambled during RUN
        launch(64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1, lat);
        chk("bp_latency", W'(lat), W'(4));
        hold_sum = 64'hFFFF_FFFF_FFFF_FFFF;
        hold_cout = 1'b0;
        for (int c = 0; c < 5; c++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            in_valid = 1'b1;
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_in_ready", W'(in_ready), W'(0));
            chk("bp_sum", sum, hold_sum);
            chk("bp_cout", W'(carry_out), W'(hold_cout));
            chk("bp_ovf", W'(ovf), W'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        take();

        // Reset during the second RUN cycle discards the operation
        @(negedge clk);
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_sum", sum, 64'h0);
        chk("mid_rst_cout", W'(carry_out), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_output", W'(seen), W'(0));

        launch(64'd3, 64'd5, 1'b0, 1'b0, lat);
        chk("post_rst_latency", W'(lat), W'(4));
        chk("post_rst_sum", sum, 64'd8);
        chk("post_rst_cout", W'(carry_out), W'(0));
        take();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
